// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the rename register file
package rf_pkg;
    localparam int TAG_NONE = 0;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int lo(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/rf_commit_resolve.sv
// rf_commit_resolve: resolves hit, winning data and tag-clear for one register across all commit ports
module rf_commit_resolve
    import rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5,
    parameter int IW   = 5,
    parameter int NWP  = 2
) (
    input  logic [IW-1:0]        idx,
    input  logic [TAGW-1:0]      cur_tag,
    input  logic [NWP-1:0]       cm_wen,
    input  logic [NWP*IW-1:0]    cm_idx,
    input  logic [NWP*TAGW-1:0]  cm_tag,
    input  logic [NWP*XLEN-1:0]  cm_data,
    output logic                 hit,
    output logic [XLEN-1:0]      data,
    output logic                 clr
);
    // ascending scan so the highest-index (youngest) valid commit wins the data
    always_comb begin
        hit  = 1'b0;
        data = '0;
        clr  = 1'b0;
        for (int k = 0; k < NWP; k++) begin
            if (cm_wen[k] && idx != '0 && cm_idx[lo(k, IW) +: IW] == idx &&
                cm_tag[lo(k, TAGW) +: TAGW] != TAGW'(TAG_NONE)) begin
                hit  = 1'b1;
                data = cm_data[lo(k, XLEN) +: XLEN];
                clr  = clr | (cm_tag[lo(k, TAGW) +: TAGW] == cur_tag);
            end
        end
    end
endmodule

// File: rtl/rename_reg_file.sv
// rename_reg_file: architectural register file with per-register ROB tag table and forwarding read ports
module rename_reg_file
    import rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int TAGW = 5,
    parameter int NRP  = 2,
    parameter int NWP  = 2,
    localparam int IW  = clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 ren_wen,
    input  logic [IW-1:0]        ren_idx,
    input  logic [TAGW-1:0]      ren_tag,
    input  logic [NWP-1:0]       cm_wen,
    input  logic [NWP*IW-1:0]    cm_idx,
    input  logic [NWP*TAGW-1:0]  cm_tag,
    input  logic [NWP*XLEN-1:0]  cm_data,
    input  logic [NRP*IW-1:0]    rd_idx,
    output logic [NRP*XLEN-1:0]  rd_data,
    output logic [NRP*TAGW-1:0]  rd_tag,
    input  logic [IW-1:0]        dbg_idx,
    output logic [XLEN-1:0]      dbg_data,
    output logic [TAGW-1:0]      dbg_tag
);
    logic [XLEN-1:0] regs [NREG];
    logic [TAGW-1:0] tags [NREG];
    logic            wr_hit [NREG];
    logic [XLEN-1:0] wr_data [NREG];
    logic            wr_clr [NREG];
    logic [IW-1:0]   ri [NRP];
    logic            r_hit [NRP];
    logic [XLEN-1:0] r_data [NRP];
    logic            r_clr [NRP];
    logic            ren_ok;

    assign ren_ok   = ren_wen && ren_idx != '0 && ren_tag != TAGW'(TAG_NONE);
    assign dbg_data = regs[dbg_idx];
    assign dbg_tag  = tags[dbg_idx];

    for (genvar r = 0; r < NREG; r++) begin : g_wr
        rf_commit_resolve #(.XLEN(XLEN), .TAGW(TAGW), .IW(IW), .NWP(NWP)) u_wr (
            .idx(IW'(r)), .cur_tag(tags[r]), .cm_wen(cm_wen), .cm_idx(cm_idx),
            .cm_tag(cm_tag), .cm_data(cm_data), .hit(wr_hit[r]), .data(wr_data[r]), .clr(wr_clr[r])
        );
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        assign ri[p] = rd_idx[p*IW +: IW];
        rf_commit_resolve #(.XLEN(XLEN), .TAGW(TAGW), .IW(IW), .NWP(NWP)) u_rd (
            .idx(ri[p]), .cur_tag(tags[ri[p]]), .cm_wen(cm_wen), .cm_idx(cm_idx),
            .cm_tag(cm_tag), .cm_data(cm_data), .hit(r_hit[p]), .data(r_data[p]), .clr(r_clr[p])
        );
    end

    // array update: data on any valid commit; tags by flush > rename > matching clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
                tags[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr_hit[r]) regs[r] <= wr_data[r];
                tags[r] <= flush ? TAGW'(TAG_NONE) :
                           (ren_ok && ren_idx == IW'(r)) ? ren_tag :
                           wr_clr[r] ? TAGW'(TAG_NONE) : tags[r];
            end
        end
    end

    // registered reads with same-cycle commit forwarding; renames are deliberately not forwarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_tag  <= '0;
        end else begin
            for (int p = 0; p < NRP; p++) begin
                rd_data[p*XLEN +: XLEN] <= r_hit[p] ? r_data[p] : regs[ri[p]];
                rd_tag[p*TAGW +: TAGW]  <= (flush || r_clr[p]) ? TAGW'(TAG_NONE) : tags[ri[p]];
            end
        end
    end
endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Parametrised architectural register file with a per-register ROB-tag (rename) table for the out-of-order core. It sits between decode/rename and the reservation stations. It accepts one rename per cycle and `NWP` in-order commits per cycle, and supports a global flush. `NRP` read ports return the registered value and the pending tag for each source register, with same-cycle commit forwarding.

## Interface
Parameters:
- `XLEN`, 32, data width
- `NREG`, 32, register count (power of two); register 0 hard-wired to zero, never tagged
- `TAGW`, 5, ROB tag width; tag 0 means "no pending producer"
- `NRP`, 2, read ports
- `NWP`, 2, commit ports; higher index = younger in program order

Ports (`IW` = log2(`NREG`)):
- `clk` in 1 clock
- `rst` in 1 asynchronous, active-high reset
- `flush` in 1 mispredict/exception flush; clears every tag
- `ren_wen` in 1 rename write enable
- `ren_idx` in `IW` destination register being renamed
- `ren_tag` in `TAGW` ROB tag assigned to it
- `cm_wen` in `NWP` commit enables
- `cm_idx` in `NWP*IW` commit destination registers
- `cm_tag` in `NWP*TAGW` committing ROB tags
- `cm_data` in `NWP*XLEN` commit results
- `rd_idx` in `NRP*IW` source register indices
- `rd_data` out `NRP*XLEN` registered read data
- `rd_tag` out `NRP*TAGW` registered pending tag (0 = value ready)
- `dbg_idx` in `IW` test-only index
- `dbg_data` out `XLEN` combinational `Regs[dbg_idx]`, test only
- `dbg_tag` out `TAGW` combinational `Tags[dbg_idx]`, test only

## Operation
- State: `Regs[NREG]` (XLEN) and `Tags[NREG]` (TAGW).
- Commit port k is valid when `cm_wen[k]`, `cm_idx[k]!=0` and `cm_tag[k]!=0`.
- Data write: every valid commit writes `Regs[cm_idx[k]] <= cm_data[k]`. If several valid commits target the same register, the highest k wins. Data writes also happen in a flush cycle.
- Tag clear: valid commit k with `Tags[cm_idx[k]]==cm_tag[k]` (pre-edge value) sets the tag to 0. A stale tag (register re-renamed since) leaves `Tags` unchanged.
- Rename: `ren_wen && ren_idx!=0 && ren_tag!=0` sets `Tags[ren_idx] <= ren_tag`. Rename has priority over any clear of the same register in the same cycle. Clears to other registers proceed in parallel.
- Flush has top priority for tags: all `Tags <= 0`. The same-cycle rename is discarded.
- Register 0: reads return data 0 and tag 0; writes, renames and clears to it are ignored.

## Timing
- Reset (async): all `Regs`, `Tags`, `rd_data` and `rd_tag` are 0.
- Read latency is 1 cycle. `rd_idx` is sampled at edge N; the outputs are valid after edge N and hold until the next edge.
- Data forwarding: if a valid commit targets `rd_idx[p]` in the sample cycle, `rd_data[p]` takes that `cm_data` (highest k). Otherwise it takes `Regs[rd_idx[p]]`.
- Tag forwarding: if a tag clear for `rd_idx[p]` happens in the sample cycle, `rd_tag[p]` is 0. Otherwise it is the pre-edge `Tags[rd_idx[p]]`.
- A same-cycle rename is NOT forwarded to read ports. The sources of the renaming instruction see the older mapping.
- In a flush cycle, every `rd_tag[p]` is 0. `rd_data` still follows the data forwarding rule.
- Reset asserted mid-operation overrides everything immediately. No partial commit survives.

## Structure
- Shared package `rf_pkg`: `TAG_NONE=0`, the `clog2`-derived `IW`, and the slice helper for flattened port vectors.
- Sub-module `rf_commit_resolve`: for one register index it returns hit, winning data and clear flag across the `NWP` ports (highest-index priority). It is instantiated per read port for forwarding and reused for the write decode.
- The top level holds the two arrays, the update priority (flush > rename > clear) and the output registers.

## Test plan
- Reset then read x5 on port 0 → `rd_data=0`, `rd_tag=0`.
- Rename x5 tag 3; next cycle read x5 → `rd_tag=3`. Commit x5 tag 3 data `0xDEAD` while reading x5 → next cycle `rd_data=0xDEAD`, `rd_tag=0`, `dbg_tag=0`.
- Rename x7 tag 4, then rename x7 tag 9; commit x7 tag 4 data 11 → `Regs[7]=11`, `dbg_tag=9` (stale, not cleared).
- Same cycle: commit x6 tag 2 (current) and rename x6 tag 8 → `dbg_tag=8`; a read of x6 that cycle returns `rd_tag=0` (rename not forwarded).
- Two ports commit x4 (port 0 data 1, port 1 data 2) → `Regs[4]=2`, forwarded `rd_data=2`.
- Rename x1..x3 tags 1..3, then assert `flush` together with rename x8 tag 5 → all `dbg_tag=0` (including x8); a commit to x0 leaves `Regs[0]=0`.
